uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter that supersedes the single-byte start/done transmitter. It adds configurable data width, parity mode and stop-bit count, plus a small input FIFO with a valid/ready handshake so producers can queue words without waiting on each frame. Frames are sent back-to-back while the FIFO is non-empty. It sits between on-chip data producers (e.g. feature/keypoint dump logic) and the board's serial TX pin.

Parameters:
CLOCKS_PER_BAUD, 33, clock cycles per serial bit; legal values are >= 2.
DATA_BITS, 8, payload bits per frame; legal values are 5..9.
PARITY, PARITY_NONE, one of PARITY_NONE, PARITY_EVEN or PARITY_ODD, taken from uart_pkg::parity_e.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.
FIFO_DEPTH, 4, input queue depth; must be a power of two and >= 2.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_ni  input  1  asynchronous, active-low reset.
data_i  input  DATA_BITS  word to enqueue.
valid_i  input  1  producer has a word on data_i.
ready_o  input/output note: this is an output  1  FIFO can accept a word (FIFO not full).
tx  output  1  serial line; idles high.
busy_o  output  1  a frame is in progress, or the FIFO is non-empty.
done_o  output  1  one-cycle pulse at the end of each frame.
level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - tx=1, ready_o=1, busy_o=0, done_o=0, level_o=0.
  - FIFO is emptied, the FSM goes to IDLE, and all counters clear.
  - If reset asserts mid-frame, tx goes high immediately and the frame is abandoned; no done_o is issued.
- Handshake:
  - A word is accepted on any rising edge where valid_i && ready_o.
  - ready_o = (level < FIFO_DEPTH). It is combinational from registered state only, never from valid_i.
  - When the FIFO is full, a push is refused even if a pop happens in the same cycle.
  - data_i need not be held after acceptance.
- FIFO: synchronous and first-word-fall-through. A push and a pop in the same cycle leave level_o unchanged.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: tx=0 for CLOCKS_PER_BAUD cycles, then go to DATA.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLOCKS_PER_BAUD cycles; shift right per bit. After DATA_BITS bits, go to PAR if PARITY != NONE, else go to STOP.
  - PAR: tx = ^word for EVEN, or ~^word for ODD, where word is the popped data. Lasts one bit time, then go to STOP.
  - STOP: tx=1 for STOP_BITS*CLOCKS_PER_BAUD cycles. done_o=1 in the last cycle of STOP.
  - End of STOP: if the FIFO is non-empty, pop and go directly to START, leaving no idle cycles between frames. Otherwise go to IDLE.
- Timing:
  - Word accepted into an empty, idle block at edge N: the FSM pops at edge N+1 and tx falls at edge N+1.
  - Frame length is exactly (1 + DATA_BITS + (PARITY != NONE) + STOP_BITS) * CLOCKS_PER_BAUD cycles.
- Counters:
  - Baud counter runs 0..CLOCKS_PER_BAUD-1, width $clog2(CLOCKS_PER_BAUD), and wraps at a bit boundary.
  - Bit counter width is $clog2(DATA_BITS+1).
- busy_o = (state != IDLE) || (level != 0).

Decomposition:
- uart_pkg holds:
  - typedef enum parity_e {PARITY_NONE, PARITY_EVEN, PARITY_ODD};
  - typedef enum tx_state_e {IDLE, START, DATA, PAR, STOP};
- One sub-module, uart_fifo: a parametrised FWFT synchronous FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, wdata, rdata, full, empty, level.
  - Same clock and reset as uart_tx_fifo.
- uart_tx_fifo holds the FSM, the baud and bit counters, and the shift register.

Test Plan:
1. Defaults (8N1, CPB=33), push 0xA5 at edge N -> tx bits 0,1,0,1,0,0,1,0,1,1, each held 33 cycles, starting at edge N+1; done_o is a single pulse 330 cycles after the start edge; busy_o then drops.
2. PARITY_EVEN, push 0x07 -> parity bit 1; PARITY_ODD, push 0x07 -> parity bit 0; PARITY_EVEN, push 0x00 -> parity bit 0; frame is 363 cycles.
3. STOP_BITS=2, DATA_BITS=7, push 0x55 -> the stop phase lasts 66 cycles; done_o fires at cycle 330 of the frame.
4. FIFO_DEPTH=4, hold valid_i for 6 words 0x01..0x06 -> ready_o drops when level_o reaches 4. All 6 words are transmitted in order with zero idle cycles between frames and 6 done_o pulses; no word is lost or duplicated.
5. Pull rst_ni low 100 cycles into a DATA bit with 3 words queued -> tx=1 and level_o=0 immediately. After release, tx stays high with no done_o and no spurious frame.
6. Push on the same edge the FSM pops the last queued word -> level_o stays constant, and the new word is sent next without a gap.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the queued UART transmitter
package uart_pkg;

  typedef enum logic [1:0] {PARITY_NONE, PARITY_EVEN, PARITY_ODD} parity_e;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_e;

  // Word is zero-extended to 9 bits by callers; padding zeros leave the XOR unchanged.
  function automatic logic parity_bit(input parity_e mode, input logic [8:0] word);
    return (mode == PARITY_ODD) ? ~^word : ^word;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - first-word-fall-through synchronous FIFO
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses pushes even when a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - parametrised UART transmitter fed by a valid/ready input queue
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int      CLOCKS_PER_BAUD = 33,
  parameter int      DATA_BITS       = 8,
  parameter parity_e PARITY          = PARITY_NONE,
  parameter int      STOP_BITS       = 1,
  parameter int      FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst_ni,
  input  logic [DATA_BITS-1:0]          data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int BAUD_W = $clog2(CLOCKS_PER_BAUD);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  tx_state_e            state, state_d;
  logic [BAUD_W-1:0]    baud_cnt, baud_d;
  logic [BIT_W-1:0]     bit_cnt, bit_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 baud_end;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_ni(rst_ni),
    .push  (valid_i),
    .pop   (pop),
    .wdata (data_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

  assign ready_o  = !fifo_full;
  assign busy_o   = (state != IDLE) || (level_o != '0);
  assign baud_end = (baud_cnt == BAUD_W'(CLOCKS_PER_BAUD - 1));

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_q    <= 1'b0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_cnt  <= bit_d;
      shift    <= shift_d;
      par_q    <= par_d;
    end
  end

  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_cnt;
    shift_d = shift;
    par_d   = par_q;
    pop     = 1'b0;
    tx      = 1'b1;
    done_o  = 1'b0;

    if (state != IDLE) begin
      baud_d = baud_end ? '0 : baud_cnt + BAUD_W'(1);
    end

    case (state)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          par_d   = parity_bit(PARITY, 9'(fifo_rdata));
          state_d = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (baud_end) state_d = DATA;
      end
      DATA: begin
        tx = shift[0];
        if (baud_end) begin
          shift_d = shift >> 1;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? PAR : STOP;
          end else begin
            bit_d = bit_cnt + BIT_W'(1);
          end
        end
      end
      PAR: begin
        tx = par_q;
        if (baud_end) state_d = STOP;
      end
      STOP: begin
        // bit_cnt is reused here to count stop bits.
        if (baud_end) begin
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            done_o = 1'b1;
            bit_d  = '0;
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = fifo_rdata;
              par_d   = parity_bit(PARITY, 9'(fifo_rdata));
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int CPB = 33;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [7:0] data;
  logic       valid;
  logic [1:0] sel;

  logic [3:0] tx_w, ready_w, busy_w, done_w;
  logic [2:0] lvl_w [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo u0 (
    .clk(clk), .rst_ni(rst_ni), .data_i(data), .valid_i(valid && sel == 2'd0),
    .ready_o(ready_w[0]), .tx(tx_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]), .level_o(lvl_w[0])
  );

  uart_tx_fifo #(.PARITY(PARITY_EVEN)) u1 (
    .clk(clk), .rst_ni(rst_ni), .data_i(data), .valid_i(valid && sel == 2'd1),
    .ready_o(ready_w[1]), .tx(tx_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]), .level_o(lvl_w[1])
  );

  uart_tx_fifo #(.PARITY(PARITY_ODD)) u2 (
    .clk(clk), .rst_ni(rst_ni), .data_i(data), .valid_i(valid && sel == 2'd2),
    .ready_o(ready_w[2]), .tx(tx_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2]), .level_o(lvl_w[2])
  );

  uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_ni(rst_ni), .data_i(data[6:0]), .valid_i(valid && sel == 2'd3),
    .ready_o(ready_w[3]), .tx(tx_w[3]), .busy_o(busy_w[3]), .done_o(done_w[3]), .level_o(lvl_w[3])
  );

  wire       tx_s    = tx_w[sel];
  wire       ready_s = ready_w[sel];
  wire       busy_s  = busy_w[sel];
  wire       done_s  = done_w[sel];
  wire [2:0] lvl_s   = lvl_w[sel];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [7:0] d);
    check({tag, "_ready"}, ready_s, 1);
    data  = d;
    valid = 1'b1;
    tick;
    valid = 1'b0;
  endtask

  // Entered one sample after the start edge; samples each bit mid-period.
  task automatic frame(input string tag, input logic [15:0] exp, input int nbits,
                       input logic idle_after, input logic push_end, input logic [7:0] pd);
    logic [15:0] got;
    int dones;
    int done_at;
    int len;
    got     = '0;
    dones   = 0;
    done_at = -1;
    len     = nbits * CPB;
    for (int t = 0; t < len; t++) begin
      if (t % CPB == CPB / 2) got[t / CPB] = tx_s;
      if (done_s) begin
        dones++;
        done_at = t + 1;
      end
      if (push_end && t == len - 1) begin
        check({tag, "_lvl_before"}, lvl_s, 1);
        data  = pd;
        valid = 1'b1;
      end
      tick;
    end
    if (push_end) begin
      valid = 1'b0;
      check({tag, "_lvl_after"}, lvl_s, 1);
    end
    check({tag, "_bits"}, got, exp);
    check({tag, "_ndone"}, dones, 1);
    check({tag, "_done_at"}, done_at, len);
    if (idle_after) begin
      check({tag, "_busy_end"}, busy_s, 0);
      check({tag, "_tx_end"}, tx_s, 1);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    valid  = 1'b0;
    data   = '0;
    sel    = 2'd0;
    repeat (3) tick;
    check("rst_tx", tx_s, 1);
    check("rst_ready", ready_s, 1);
    check("rst_busy", busy_s, 0);
    check("rst_done", done_s, 0);
    check("rst_level", lvl_s, 0);
    rst_ni = 1'b1;
    repeat (2) tick;
    check("post_rst_tx", tx_s, 1);
    check("post_rst_busy", busy_s, 0);

    // 8N1 single word
    push("a5", 8'hA5);
    check("a5_busy", busy_s, 1);
    tick;
    frame("a5", 16'h034A, 10, 1'b1, 1'b0, 8'h00);

    // parity variants
    sel = 2'd1;
    push("even07", 8'h07);
    tick;
    frame("even07", 16'h060E, 11, 1'b1, 1'b0, 8'h00);
    sel = 2'd2;
    push("odd07", 8'h07);
    tick;
    frame("odd07", 16'h040E, 11, 1'b1, 1'b0, 8'h00);
    sel = 2'd1;
    push("even00", 8'h00);
    tick;
    frame("even00", 16'h0400, 11, 1'b1, 1'b0, 8'h00);

    // 7 data bits, two stop bits
    sel = 2'd3;
    push("s2_55", 8'h55);
    tick;
    frame("s2_55", 16'h03AA, 10, 1'b1, 1'b0, 8'h00);

    // queue 6 words through a depth-4 FIFO
    sel = 2'd0;
    fork
      begin : producer
        int w;
        int budget;
        int max_lvl;
        int bad;
        logic acc;
        w = 1; budget = 0; max_lvl = 0; bad = 0;
        data  = 8'd1;
        valid = 1'b1;
        while (w <= 6 && budget < 2000) begin
          acc = ready_s;
          if (int'(lvl_s) > max_lvl) max_lvl = int'(lvl_s);
          if ((lvl_s == 3'd4) == ready_s) bad++;
          tick;
          budget++;
          if (acc) begin
            w++;
            data = 8'(w);
          end
        end
        valid = 1'b0;
        check("q_accepted", w, 7);
        check("q_max_level", max_lvl, 4);
        check("q_ready_vs_full", bad, 0);
      end
      begin : consumer
        tick;
        tick;
        for (int i = 0; i < 6; i++) begin
          frame($sformatf("q%0d", i + 1), 16'h0200 | 16'((i + 1) << 1), 10, i == 5, 1'b0, 8'h00);
        end
      end
    join

    // push on the same edge the FSM pops the last queued word
    push("pp_a", 8'h3C);
    push("pp_b", 8'hC3);
    frame("pp_a", 16'h0278, 10, 1'b0, 1'b1, 8'h5A);
    frame("pp_b", 16'h0386, 10, 1'b0, 1'b0, 8'h00);
    frame("pp_c", 16'h02B4, 10, 1'b1, 1'b0, 8'h00);

    // reset mid-DATA with three words queued
    push("rs1", 8'h11);
    push("rs2", 8'h22);
    push("rs3", 8'h33);
    push("rs4", 8'h44);
    check("rs_level", lvl_s, 3);
    repeat (131) tick;
    rst_ni = 1'b0;
    #1;
    check("rs_tx", tx_s, 1);
    check("rs_lvl", lvl_s, 0);
    check("rs_ready", ready_s, 1);
    check("rs_busy", busy_s, 0);
    check("rs_done", done_s, 0);
    repeat (3) tick;
    rst_ni = 1'b1;
    begin : after_reset
      int lows;
      int dones;
      lows = 0;
      dones = 0;
      for (int t = 0; t < 400; t++) begin
        if (!tx_s) lows++;
        if (done_s) dones++;
        tick;
      end
      check("rs_quiet_tx", lows, 0);
      check("rs_quiet_done", dones, 0);
      check("rs_quiet_lvl", lvl_s, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
